// File: rtl/spm_loader_pkg.sv
// Shared types and constants for the FlexPRET scratchpad loader.
// Build option SPM_LOADER_TIMEOUT_EN (see spm_loader_ctrl) adds a run watchdog.
package spm_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_LO,
    ST_CNT_HI,
    ST_DATA,
    ST_WRITE,
    ST_RUN,
    ST_DONE
  } state_e;

  localparam logic [7:0]  CMD_I     = 8'h49;
  localparam logic [7:0]  CMD_D     = 8'h44;
  localparam logic [7:0]  CMD_R     = 8'h52;
  localparam logic [7:0]  CMD_S     = 8'h53;
  localparam logic [31:0] PASS_CODE = 32'd1;

  // Failure codes are small positive values; the top two bits mark non-result traffic.
  function automatic logic is_fail_code(input logic [31:0] v);
    return (v[31:30] == 2'b00) && (v > PASS_CODE);
  endfunction

endpackage

// File: rtl/spm_loader_ctrl_if.sv
// Byte-stream, scratchpad-write and core-control signals between the loader and its neighbours.
interface spm_loader_ctrl_if #(
  parameter int unsigned ADDR_W = 12
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              core_reset;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_enable;
  logic              imem_write;
  logic [31:0]       imem_data_in;
  logic [ADDR_W-1:0] dmem_addr;
  logic              dmem_enable;
  logic [3:0]        dmem_byte_write;
  logic [31:0]       dmem_data_in;
  logic [31:0]       tohost;

  modport master (
    input  rx_data, rx_valid, tohost,
    output rx_ready, core_reset,
    output imem_addr, imem_enable, imem_write, imem_data_in,
    output dmem_addr, dmem_enable, dmem_byte_write, dmem_data_in
  );

  modport slave (
    output rx_data, rx_valid, tohost,
    input  rx_ready, core_reset,
    input  imem_addr, imem_enable, imem_write, imem_data_in,
    input  dmem_addr, dmem_enable, dmem_byte_write, dmem_data_in
  );
endinterface

// File: rtl/spm_word_packer.sv
// Assembles little-endian 32-bit words from a byte stream; word_valid_o pulses the cycle after byte 4.
module spm_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        last_o,
  output logic [31:0] word_o,
  output logic        word_valid_o
);
  logic [1:0]  cnt_q;
  logic [31:0] shift_q;
  logic        valid_q;

  always_ff @(posedge clk) begin
    if (!reset || clr_i) begin
      cnt_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= byte_valid_i && (cnt_q == 2'd3);
      if (byte_valid_i) begin
        shift_q <= {byte_i, shift_q[31:8]};
        cnt_q   <= cnt_q + 2'd1;
      end
    end
  end

  assign last_o       = (cnt_q == 2'd3);
  assign word_o       = shift_q;
  assign word_valid_o = valid_q;
endmodule

// File: rtl/spm_loader_ctrl.sv
// Loads FlexPRET ISPM/DSPM from a byte stream, runs the core and latches pass/fail.
// Define SPM_LOADER_TIMEOUT_EN to add a MAX_CYCLES run watchdog.
module spm_loader_ctrl
  import spm_loader_pkg::*;
#(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DEPTH      = 4096,
  parameter int unsigned MAX_CYCLES = 10000
) (
  input  logic               clk,
  input  logic               reset,
  spm_loader_ctrl_if.master  bus,
  output logic               busy_o,
  output logic               passed_o,
  output logic               failed_o,
  output logic [31:0]        fail_code_o,
  output logic               timeout_o,
  output logic               cmd_err_o
);
  state_e            state_q, state_d;
  logic              sel_dmem_q, sel_dmem_d;
  logic [7:0]        cnt_lo_q, cnt_lo_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              first_q, first_d;
  logic              passed_q, passed_d, failed_q, failed_d;
  logic              timeout_q, timeout_d, cmd_err_q, cmd_err_d;
  logic [31:0]       fail_code_q, fail_code_d;
`ifdef SPM_LOADER_TIMEOUT_EN
  logic [31:0]       cyc_q, cyc_d;
`endif

  logic        accept, pk_clr, pk_last, pk_valid, wr_i, wr_d;
  logic [31:0] pk_word;
  logic [15:0] cnt_n;

  assign accept = bus.rx_valid && bus.rx_ready;
  assign cnt_n  = {bus.rx_data, cnt_lo_q};

  spm_word_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .clr_i        (pk_clr),
    .byte_valid_i (accept && (state_q == ST_DATA)),
    .byte_i       (bus.rx_data),
    .last_o       (pk_last),
    .word_o       (pk_word),
    .word_valid_o (pk_valid)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      sel_dmem_q  <= 1'b0;
      cnt_lo_q    <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      first_q     <= 1'b0;
      passed_q    <= 1'b0;
      failed_q    <= 1'b0;
      timeout_q   <= 1'b0;
      cmd_err_q   <= 1'b0;
      fail_code_q <= '0;
`ifdef SPM_LOADER_TIMEOUT_EN
      cyc_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sel_dmem_q  <= sel_dmem_d;
      cnt_lo_q    <= cnt_lo_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      first_q     <= first_d;
      passed_q    <= passed_d;
      failed_q    <= failed_d;
      timeout_q   <= timeout_d;
      cmd_err_q   <= cmd_err_d;
      fail_code_q <= fail_code_d;
`ifdef SPM_LOADER_TIMEOUT_EN
      cyc_q       <= cyc_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_dmem_d  = sel_dmem_q;
    cnt_lo_d    = cnt_lo_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    first_d     = first_q;
    passed_d    = passed_q;
    failed_d    = failed_q;
    timeout_d   = timeout_q;
    cmd_err_d   = cmd_err_q;
    fail_code_d = fail_code_q;
    pk_clr      = 1'b0;
`ifdef SPM_LOADER_TIMEOUT_EN
    cyc_d       = cyc_q;
`endif
    unique case (state_q)
      ST_IDLE, ST_DONE: if (accept) begin
        case (bus.rx_data)
          CMD_I: begin sel_dmem_d = 1'b0; state_d = ST_CNT_LO; end
          CMD_D: begin sel_dmem_d = 1'b1; state_d = ST_CNT_LO; end
          CMD_R: begin
            state_d     = ST_RUN;
            first_d     = 1'b1;
            passed_d    = 1'b0;
            failed_d    = 1'b0;
            timeout_d   = 1'b0;
            fail_code_d = '0;
`ifdef SPM_LOADER_TIMEOUT_EN
            cyc_d       = '0;
`endif
          end
          default: cmd_err_d = 1'b1;
        endcase
      end
      ST_CNT_LO: if (accept) begin
        cnt_lo_d = bus.rx_data;
        state_d  = ST_CNT_HI;
      end
      ST_CNT_HI: if (accept) begin
        if (cnt_n == 16'd0) begin
          state_d = ST_IDLE;
        end else if (32'(cnt_n) > DEPTH) begin
          cmd_err_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d   = cnt_n;
          idx_d   = '0;
          pk_clr  = 1'b1;
          state_d = ST_DATA;
        end
      end
      ST_DATA: if (accept && pk_last) state_d = ST_WRITE;
      ST_WRITE: begin
        idx_d   = idx_q + ADDR_W'(1);
        state_d = ((16'(idx_q) + 16'd1) == cnt_q) ? ST_IDLE : ST_DATA;
      end
      ST_RUN: begin
        // tohost is ignored in the first RUN cycle while the core leaves reset.
        first_d = 1'b0;
`ifdef SPM_LOADER_TIMEOUT_EN
        cyc_d   = cyc_q + 32'd1;
`endif
        if (!first_q && bus.tohost == PASS_CODE) begin
          passed_d = 1'b1;
          state_d  = ST_DONE;
        end else if (!first_q && is_fail_code(bus.tohost)) begin
          failed_d    = 1'b1;
          fail_code_d = bus.tohost;
          state_d     = ST_DONE;
`ifdef SPM_LOADER_TIMEOUT_EN
        end else if (cyc_d > MAX_CYCLES) begin
          timeout_d   = 1'b1;
          failed_d    = 1'b1;
          fail_code_d = '0;
          state_d     = ST_DONE;
`endif
        end else if (accept && bus.rx_data == CMD_S) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wr_i = (state_q == ST_WRITE) && pk_valid && !sel_dmem_q;
  assign wr_d = (state_q == ST_WRITE) && pk_valid &&  sel_dmem_q;

  assign bus.rx_ready        = (state_q != ST_WRITE);
  assign bus.core_reset      = (state_q != ST_RUN);
  assign bus.imem_enable     = wr_i;
  assign bus.imem_write      = wr_i;
  assign bus.imem_addr       = wr_i ? idx_q : '0;
  assign bus.imem_data_in    = wr_i ? pk_word : '0;
  assign bus.dmem_enable     = wr_d;
  assign bus.dmem_byte_write = wr_d ? 4'hF : 4'h0;
  assign bus.dmem_addr       = wr_d ? idx_q : '0;
  assign bus.dmem_data_in    = wr_d ? pk_word : '0;

  assign busy_o      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign passed_o    = passed_q;
  assign failed_o    = failed_q;
  assign fail_code_o = fail_code_q;
  assign timeout_o   = timeout_q;
  assign cmd_err_o   = cmd_err_q;
endmodule
